// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store stage that sits directly after the EX ALU.
// ALU results are forwarded to writeback one cycle after acceptance. Loads and
// stores each issue a single data-memory request using a req/gnt handshake,
// and a load then completes on rvalid. EX is stalled (ex_ready low) while an
// access is outstanding. Load data is sign- or zero-extended here.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword
// and word accesses. A trapped access issues no memory request and produces
// a writeback pulse with misalign=1. Without the macro, the low address bits
// are dropped and misalign is tied to 0.
module mem_access_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_mem_rd,
  input  logic            ex_mem_wr,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_reg_wr,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_reg_wr,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      cap_funct3;
  logic [1:0]      cap_off;
  logic [RD_W-1:0] cap_rd;
  logic            cap_reg_wr;

  logic            accept;
  logic            mem_op;
  logic            trap;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid & ex_ready;
  assign mem_op   = ex_mem_rd | ex_mem_wr;

  // Pick the byte or halfword selected by the captured offset, then extend it
  function automatic logic [XLEN-1:0] format_load(input logic [2:0] f3,
                                                  input logic [1:0] off,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b100:  format_load = {24'b0, b};
      3'b101:  format_load = {16'b0, h};
      default: format_load = word;
    endcase
  endfunction

  // Store byte enables and lane-replicated write data; loads read the full word
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_rs2_data;
    if (ex_mem_wr) begin
      case (ex_funct3)
        3'b000: begin
          st_be    = 4'b0001 << ex_alu_out[1:0];
          st_wdata = {4{ex_rs2_data[7:0]}};
        end
        3'b001: begin
          st_be    = 4'b0011 << {ex_alu_out[1], 1'b0};
          st_wdata = {2{ex_rs2_data[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = ex_rs2_data;
        end
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic is_half;
  logic is_byte;
  logic misalign_q;

  // Classify access size; funct3 aliases fall into the word class
  always_comb begin
    is_half = 1'b0;
    is_byte = 1'b0;
    if (ex_mem_wr) begin
      is_byte = (ex_funct3 == 3'b000);
      is_half = (ex_funct3 == 3'b001);
    end else begin
      is_byte = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b100);
      is_half = (ex_funct3 == 3'b001) || (ex_funct3 == 3'b101);
    end
  end

  assign trap     = mem_op & ((is_half & ex_alu_out[0]) |
                              (~is_half & ~is_byte & (ex_alu_out[1:0] != 2'b00)));
  assign misalign = misalign_q;

  // One-cycle misalign pulse alongside the trap writeback
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= accept & trap;
  end
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  // Main control FSM: accept, issue memory request, wait for response, write back
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'b0;
      wb_valid   <= 1'b0;
      wb_reg_wr  <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      cap_funct3 <= 3'b0;
      cap_off    <= 2'b0;
      cap_rd     <= '0;
      cap_reg_wr <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!mem_op) begin
              wb_valid  <= 1'b1;
              wb_data   <= ex_alu_out;
              wb_reg_wr <= ex_reg_wr;
              wb_rd     <= ex_rd;
            end else if (trap) begin
              wb_valid  <= 1'b1;
              wb_data   <= ex_alu_out;
              wb_reg_wr <= 1'b0;
              wb_rd     <= ex_rd;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= ex_mem_wr;
              dmem_addr  <= {ex_alu_out[XLEN-1:2], 2'b00};
              dmem_wdata <= st_wdata;
              dmem_be    <= st_be;
              cap_funct3 <= ex_funct3;
              cap_off    <= ex_alu_out[1:0];
              cap_rd     <= ex_rd;
              cap_reg_wr <= ex_reg_wr;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              wb_valid  <= 1'b1;
              wb_reg_wr <= 1'b0;
              wb_rd     <= cap_rd;
              state     <= IDLE;
            end else if (dmem_rvalid) begin
              wb_valid  <= 1'b1;
              wb_reg_wr <= cap_reg_wr;
              wb_rd     <= cap_rd;
              wb_data   <= format_load(cap_funct3, cap_off, dmem_rdata);
              state     <= IDLE;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            wb_valid  <= 1'b1;
            wb_reg_wr <= cap_reg_wr;
            wb_rd     <= cap_rd;
            wb_data   <= format_load(cap_funct3, cap_off, dmem_rdata);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
